ex_stage_ctrl: RTL and testbench
================================

Name: ex_stage_ctrl

Overview:
- Execute-stage sequencer on the issuing side of the 16-bit pipeline ALU.
- Accepts decoded ops from ID over valid/ready and registers them.
- Drives funct/Rout1/Rout2 into the combinational ALU, holding multiply/divide operands stable for a programmable number of cycles.
- Captures result/R0/branch into the EX/MEM register with downstream backpressure, and raises a one-cycle flush on a taken branch.

Parameters:
- MULDIV_LAT, 3, cycles operands are held for funct 4'h1 (multiply) and 4'h2 (divide) before capture; legal range 1..15.
- FUNCT_MUL, 4'h1, funct code for multiply; R0 receives the product high half.
- FUNCT_DIV, 4'h2, funct code for divide; R0 receives the remainder.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ID presents an op.
- in_ready  out  1  stage accepts the op this cycle.
- in_funct  in  4  ALU function code.
- in_op1  in  16  first operand, signed.
- in_op2  in  16  second operand, signed.
- in_rd  in  4  destination register index.
- alu_funct  out  4  registered funct to ALU.
- alu_rout1  out  16  registered operand 1 to ALU.
- alu_rout2  out  16  registered operand 2 to ALU.
- alu_result  in  16  ALU result.
- alu_r0  in  16  ALU R0 (mul high / div remainder).
- alu_branch  in  1  ALU branch-taken flag.
- out_valid  out  1  EX/MEM register holds a valid op.
- out_ready  in  1  MEM consumes the op.
- out_result  out  16  captured result.
- out_rd  out  4  captured destination index.
- out_r0  out  16  captured R0 value.
- out_r0_we  out  1  R0 write enable; 1 only for mul/div.
- out_branch  out  1  captured branch flag.
- flush  out  1  one-cycle pulse: kill younger ops in IF/ID.

Behaviour:
- Reset (rst_n=0 at edge): op_valid=0, cnt=0, alu_funct/alu_rout1/alu_rout2=0, out_valid=0, out_result/out_r0/out_rd=0, out_r0_we=0, out_branch=0. flush=0 while op_valid=0.
- Operand register: op_valid, op_rd, cnt; the alu_* outputs are this register's contents.
- Accept when in_valid && in_ready. Loads funct/op1/op2/rd, sets op_valid=1, and sets cnt=MULDIV_LAT-1 for mul/div, else cnt=0.
- While op_valid && cnt!=0: cnt decrements each cycle; the operand register is held.
- done = op_valid && cnt==0.
- capture = done && (!out_valid || out_ready). On capture:
  - out_result<=alu_result, out_r0<=alu_r0, out_rd<=op_rd, out_branch<=alu_branch, out_valid<=1.
  - out_r0_we<=1 iff funct is mul/div.
- flush = capture && alu_branch (combinational, exactly one cycle).
- in_ready = (!op_valid || capture) && !flush.
  - Back-to-back single-cycle ops: throughput 1/cycle.
  - Mul/div: throughput 1 per MULDIV_LAT cycles.
- On capture without a simultaneous accept, op_valid<=0.
- On flush, no accept that cycle; op_valid<=0.
- Latency from accept to out_valid: 1 cycle for normal ops, MULDIV_LAT cycles for mul/div (when out not stalled).
- Output hold: out_valid && !out_ready keeps the out_* registers unchanged. The operand register also stalls when done, keeping alu_* stable. No op is dropped or duplicated.
- out_valid && out_ready && !capture: out_valid<=0.
- Simultaneous consume + capture: the new op replaces the old one in the same cycle; out_valid stays 1.
- Reset mid-operation (during mul/div countdown or output stall): everything returns to reset values next edge; the partial op is discarded; no flush.
- Widths: no arithmetic here besides the 4-bit cnt; operands pass through unmodified and signed values are not reinterpreted.

Decomposition:
- Shared package cpu_pkg: funct localparams (FUNCT_MUL=4'h1, FUNCT_DIV=4'h2, remaining ALU codes 4'h8..4'hF), DATA_W=16, REG_IDX_W=4.
- No sub-module needed. The ALU is instantiated beside this block in the EX stage wrapper, not inside it.

Test Plan:
- Bench uses a behavioural ALU stub: mul = full product, div = quotient/remainder, other functs = op1+op2, branch=1 iff funct=4'h3.
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> out_valid=0, in_ready=1, alu_funct=0, flush=0 throughout; no accept.
- Single op: funct=4'hF, op1=5, op2=7, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=12, out_rd=3, out_r0_we=0; four back-to-back ops emerge on consecutive cycles.
- Multiply MULDIV_LAT=3: op1=16'h4000, op2=4 -> in_ready=0 for 2 cycles; out_result=0, out_r0=1, out_r0_we=1 on cycle 3. Divide 5/4 -> out_result=1, out_r0=1.
- Backpressure: out_ready=0 for 5 cycles with 3 ops queued -> out_* held, second op parked in the operand register, in_ready=0; release -> ops 1, 2, 3 delivered in order, no loss or duplication.
- Branch: funct=4'h3 followed by in_valid=1 -> flush=1 for exactly one cycle, in_ready=0 that cycle, out_branch=1; the following op is accepted only on the next cycle.
- Reset mid-multiply (cnt=1): rst_n=0 for one edge -> op_valid=0, out_valid=0; no output produced for the killed op.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared EX-stage definitions: ALU function codes, datapath widths and the
// operand/result records passed between the ID, EX and MEM boundaries.
package cpu_pkg;
  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 4;
  localparam int FUNCT_W   = 4;

  localparam logic [FUNCT_W-1:0] FUNCT_MUL      = 4'h1;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV      = 4'h2;
  localparam logic [FUNCT_W-1:0] FUNCT_ALU_LO   = 4'h8;
  localparam logic [FUNCT_W-1:0] FUNCT_ALU_HI   = 4'hF;

  typedef struct packed {
    logic [FUNCT_W-1:0]   funct;
    logic [DATA_W-1:0]    op1;
    logic [DATA_W-1:0]    op2;
    logic [REG_IDX_W-1:0] rd;
  } ex_op_t;

  typedef struct packed {
    logic [DATA_W-1:0]    result;
    logic [DATA_W-1:0]    r0;
    logic [REG_IDX_W-1:0] rd;
    logic                 r0_we;
    logic                 branch;
  } ex_res_t;
endpackage

// File: rtl/ex_stage_ctrl_if.sv
// EX-stage bus: ID handshake, ALU operand/result lines and EX/MEM handshake.
// master = the sequencer, slave = its surroundings (ID, ALU, MEM).
interface ex_stage_ctrl_if;
  import cpu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [FUNCT_W-1:0]   in_funct;
  logic [DATA_W-1:0]    in_op1;
  logic [DATA_W-1:0]    in_op2;
  logic [REG_IDX_W-1:0] in_rd;

  logic [FUNCT_W-1:0]   alu_funct;
  logic [DATA_W-1:0]    alu_rout1;
  logic [DATA_W-1:0]    alu_rout2;
  logic [DATA_W-1:0]    alu_result;
  logic [DATA_W-1:0]    alu_r0;
  logic                 alu_branch;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_result;
  logic [REG_IDX_W-1:0] out_rd;
  logic [DATA_W-1:0]    out_r0;
  logic                 out_r0_we;
  logic                 out_branch;
  logic                 flush;

  modport master (
    input  in_valid, in_funct, in_op1, in_op2, in_rd,
    input  alu_result, alu_r0, alu_branch, out_ready,
    output in_ready, alu_funct, alu_rout1, alu_rout2,
    output out_valid, out_result, out_rd, out_r0, out_r0_we, out_branch, flush
  );

  modport slave (
    output in_valid, in_funct, in_op1, in_op2, in_rd,
    output alu_result, alu_r0, alu_branch, out_ready,
    input  in_ready, alu_funct, alu_rout1, alu_rout2,
    input  out_valid, out_result, out_rd, out_r0, out_r0_we, out_branch, flush
  );
endinterface

// File: rtl/ex_stage_ctrl.sv
// Execute-stage sequencer: registers ID ops, holds ALU operands for mul/div,
// captures ALU results into EX/MEM under backpressure, flushes on taken branch.
module ex_stage_ctrl #(
  parameter int unsigned        MULDIV_LAT = 3,
  parameter logic [3:0]         FUNCT_MUL  = cpu_pkg::FUNCT_MUL,
  parameter logic [3:0]         FUNCT_DIV  = cpu_pkg::FUNCT_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_stage_ctrl_if.master bus
);
  import cpu_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 1);

  ex_op_t     op_q;
  logic       op_valid;
  logic [3:0] cnt;
  ex_res_t    out_q;
  logic       out_valid_q;

  logic done, capture, flush, accept;
  logic in_muldiv, op_muldiv;

  assign in_muldiv = (bus.in_funct == FUNCT_MUL) || (bus.in_funct == FUNCT_DIV);
  assign op_muldiv = (op_q.funct  == FUNCT_MUL) || (op_q.funct  == FUNCT_DIV);

  assign done    = op_valid && (cnt == 4'd0);
  // A full EX/MEM slot may still capture when MEM drains it this same cycle.
  assign capture = done && (!out_valid_q || bus.out_ready);
  assign flush   = capture && bus.alu_branch;
  assign accept  = bus.in_valid && bus.in_ready;

  assign bus.in_ready = (!op_valid || capture) && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      op_valid    <= 1'b0;
      cnt         <= 4'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= '{funct: bus.in_funct, op1: bus.in_op1, op2: bus.in_op2, rd: bus.in_rd};
        op_valid <= 1'b1;
        cnt      <= in_muldiv ? CNT_INIT : 4'd0;
      end else if (capture) begin
        op_valid <= 1'b0;
      end else if (op_valid && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        out_q       <= '{result: bus.alu_result, r0: bus.alu_r0, rd: op_q.rd,
                         r0_we: op_muldiv, branch: bus.alu_branch};
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_funct  = op_q.funct;
  assign bus.alu_rout1  = op_q.op1;
  assign bus.alu_rout2  = op_q.op2;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_q.result;
  assign bus.out_r0     = out_q.r0;
  assign bus.out_rd     = out_q.rd;
  assign bus.out_r0_we  = out_q.r0_we;
  assign bus.out_branch = out_q.branch;
  assign bus.flush      = flush;
endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed + randomized bench for ex_stage_ctrl with a behavioural ALU stub
// and an in-order scoreboard of expected EX/MEM results.
module tb_ex_stage_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_ctrl_if bus();

  ex_stage_ctrl #(.MULDIV_LAT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passed = 0;
  int nflush = 0;
  int nbr    = 0;
  bit mon_en = 1'b0;
  ex_res_t sb[$];

  // Reference ALU behaviour: mul full product, div quotient/remainder, else add.
  function automatic ex_res_t model(input ex_op_t op);
    ex_res_t r;
    logic signed [31:0] a, b, p, q, m;
    a = {{16{op.op1[15]}}, op.op1};
    b = {{16{op.op2[15]}}, op.op2};
    r = '0;
    r.rd     = op.rd;
    r.branch = (op.funct == 4'h3);
    if (op.funct == 4'h1) begin
      p = a * b;
      r.result = p[15:0];
      r.r0     = p[31:16];
      r.r0_we  = 1'b1;
    end else if (op.funct == 4'h2) begin
      if (b == 0) begin
        r.result = 16'hFFFF;
        r.r0     = op.op1;
      end else begin
        q = a / b;
        m = a % b;
        r.result = q[15:0];
        r.r0     = m[15:0];
      end
      r.r0_we = 1'b1;
    end else begin
      r.result = op.op1 + op.op2;
    end
    return r;
  endfunction

  ex_res_t stub;
  always_comb begin
    stub = model('{funct: bus.alu_funct, op1: bus.alu_rout1, op2: bus.alu_rout2, rd: 4'd0});
  end
  assign bus.alu_result = stub.result;
  assign bus.alu_r0     = stub.r0;
  assign bus.alu_branch = stub.branch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd);
    bus.in_valid = 1'b1;
    bus.in_funct = f;
    bus.in_op1   = a;
    bus.in_op2   = b;
    bus.in_rd    = rd;
  endtask

  function automatic logic [37:0] outs();
    return {bus.out_result, bus.out_r0, bus.out_rd, bus.out_r0_we, bus.out_branch};
  endfunction

  // Scoreboard monitor: inputs only change #1 after posedge, so negedge values
  // are exactly what the next rising edge samples.
  bit          prev_stall = 1'b0;
  bit          prev_flush = 1'b0;
  logic [37:0] prev_out;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        sb.delete();
        prev_stall = 1'b0;
        prev_flush = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(bus.out_valid), 64'd1);
          chk("hold_data", 64'(outs()), 64'(prev_out));
        end
        if (bus.flush) begin
          chk("flush_blocks_ready", 64'(bus.in_ready), 64'd0);
          chk("flush_single", 64'(prev_flush), 64'd0);
          nflush++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) chk("sb_underflow", 64'(sb.size() == 0), 64'd0);
          else begin
            ex_res_t e;
            e = sb.pop_front();
            chk("sb_out", 64'(outs()), 64'(e));
            if (e.branch) nbr++;
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb.push_back(model('{funct: bus.in_funct, op1: bus.in_op1, op2: bus.in_op2,
                               rd: bus.in_rd}));
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = outs();
        prev_flush = bus.flush;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a pending op that must not be accepted.
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'hF, 16'd5, 16'd7, 4'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_alu_funct", 64'(bus.alu_funct), 64'd0);
      chk("rst_flush", 64'(bus.flush), 64'd0);
    end
    bus.in_valid = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single add-class op.
    drive(4'hF, 16'd5, 16'd7, 4'd3);
    step();
    bus.in_valid = 1'b0;
    chk("single_pre_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_result", 64'(bus.out_result), 64'd12);
    chk("single_rd", 64'(bus.out_rd), 64'd3);
    chk("single_we", 64'(bus.out_r0_we), 64'd0);

    // Four back-to-back ops, one per cycle.
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", 64'(bus.in_ready), 64'd1);
      drive(4'hF, 16'(i * 10), 16'd1, 4'(4 + i));
      step();
      if (i > 0) begin
        chk("b2b_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_rd", 64'(bus.out_rd), 64'(3 + i));
      end
    end
    bus.in_valid = 1'b0;
    step();
    chk("b2b_last_rd", 64'(bus.out_rd), 64'd7);
    chk("b2b_last_res", 64'(bus.out_result), 64'd31);

    // Multiply: operands held for 3 cycles.
    drive(4'h1, 16'h4000, 16'd4, 4'd2);
    step();
    bus.in_valid = 1'b0;
    chk("mul_ready0", 64'(bus.in_ready), 64'd0);
    chk("mul_alu_funct", 64'(bus.alu_funct), 64'd1);
    step();
    chk("mul_ready1", 64'(bus.in_ready), 64'd0);
    chk("mul_not_yet", 64'(bus.out_valid), 64'd0);
    step();
    chk("mul_ready2", 64'(bus.in_ready), 64'd1);
    chk("mul_not_yet2", 64'(bus.out_valid), 64'd0);
    step();
    chk("mul_valid", 64'(bus.out_valid), 64'd1);
    chk("mul_result", 64'(bus.out_result), 64'd0);
    chk("mul_r0", 64'(bus.out_r0), 64'd1);
    chk("mul_we", 64'(bus.out_r0_we), 64'd1);

    // Divide 5/4.
    drive(4'h2, 16'd5, 16'd4, 4'd6);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("div_not_yet", 64'(bus.out_valid), 64'd0);
    step();
    chk("div_valid", 64'(bus.out_valid), 64'd1);
    chk("div_result", 64'(bus.out_result), 64'd1);
    chk("div_r0", 64'(bus.out_r0), 64'd1);
    step();
    chk("div_drained", 64'(bus.out_valid), 64'd0);

    // Backpressure with three ops queued.
    bus.out_ready = 1'b0;
    drive(4'hF, 16'd100, 16'd1, 4'd1);
    step();
    drive(4'hF, 16'd200, 16'd2, 4'd2);
    step();
    drive(4'hF, 16'd300, 16'd3, 4'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_rd", 64'(bus.out_rd), 64'd1);
      chk("bp_result", 64'(bus.out_result), 64'd101);
      chk("bp_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_parked", 64'(bus.alu_rout1), 64'd200);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("bp_op2_rd", 64'(bus.out_rd), 64'd2);
    chk("bp_op2_res", 64'(bus.out_result), 64'd202);
    step();
    chk("bp_op3_rd", 64'(bus.out_rd), 64'd3);
    chk("bp_op3_res", 64'(bus.out_result), 64'd303);
    step();
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // Taken branch followed immediately by another op.
    drive(4'h3, 16'd1, 16'd2, 4'd7);
    step();
    drive(4'hF, 16'd3, 16'd4, 4'd8);
    chk("br_flush", 64'(bus.flush), 64'd1);
    chk("br_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("br_flush_end", 64'(bus.flush), 64'd0);
    chk("br_ready_back", 64'(bus.in_ready), 64'd1);
    chk("br_out_branch", 64'(bus.out_branch), 64'd1);
    chk("br_out_rd", 64'(bus.out_rd), 64'd7);
    step();
    bus.in_valid = 1'b0;
    chk("br_next_noflush", 64'(bus.flush), 64'd0);
    step();
    chk("br_next_rd", 64'(bus.out_rd), 64'd8);
    chk("br_next_branch", 64'(bus.out_branch), 64'd0);
    step();

    // Reset during multiply countdown.
    drive(4'h1, 16'd3, 16'd5, 4'd9);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("mr_alu_funct", 64'(bus.alu_funct), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mr_alu_funct0", 64'(bus.alu_funct), 64'd0);
    chk("mr_flush", 64'(bus.flush), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_no_output", 64'(bus.out_valid), 64'd0);
    end

    // Randomized traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 10);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_funct  = (r < 3) ? 4'(r + 1) : 4'(r + 5);
      bus.in_op1    = 16'($urandom);
      bus.in_op2    = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
      bus.in_rd     = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 50 && (sb.size() != 0 || bus.out_valid); n++) step();
    step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_count", 64'(nflush), 64'(nbr));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
